shift_reg_universal: RTL and testbench

- Universal shift register, downstream of the 2-bit binary counter `contador`.
- The counter's `count[1:0]` output drives this block's `mode` input directly.
- Modes: hold, shift left, shift right, parallel load; optional rotation.
- Tracks how many original bits have been shifted out since the last load and flags when the register holds no loaded data.

---
 rtl/shift_reg_universal_if.sv | 28 ++
 rtl/shift_reg_universal.sv | 80 ++++++++
 tb/tb_shift_reg_universal.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_universal_if.sv
// Universal shift register bus: control, serial/parallel data and status.
// Master drives controls and data; slave returns register state.
interface shift_reg_universal_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             enable;
    logic [1:0]       mode;
    logic             rot;
    logic             s_in_l;
    logic             s_in_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic [CNT_W-1:0] shifts;
    logic             vacio;
    logic             load_ack;

    modport master (
        output enable, mode, rot, s_in_l, s_in_r, d,
        input  q, s_out, shifts, vacio, load_ack
    );

    modport slave (
        input  enable, mode, rot, s_in_l, s_in_r, d,
        output q, s_out, shifts, vacio, load_ack
    );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold / left / right / load, optional rotate,
// with a saturating count of loaded bits shifted out since the last load.
module shift_reg_universal #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_reg_universal_if.slave  bus
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic [CNT_W-1:0] shifts_q, shifts_d;
    logic             load_ack_q, load_ack_d;
    logic             fill_l, fill_r;

    // Fill bits entering on a shift: wrap-around when rotating.
    always_comb begin
        fill_l = bus.rot ? q_q[WIDTH-1] : bus.s_in_r;
        fill_r = bus.rot ? q_q[0] : bus.s_in_l;
    end

    // Next state; ack defaults low so any non-load or gated edge clears it.
    always_comb begin
        q_d        = q_q;
        s_out_d    = s_out_q;
        shifts_d   = shifts_q;
        load_ack_d = 1'b0;
        if (bus.enable) begin
            unique case (bus.mode)
                2'b00: begin
                end
                2'b01: begin
                    q_d     = {q_q[WIDTH-2:0], fill_l};
                    s_out_d = q_q[WIDTH-1];
                    if (!bus.rot && shifts_q != FULL)
                        shifts_d = shifts_q + ONE;
                end
                2'b10: begin
                    q_d     = {fill_r, q_q[WIDTH-1:1]};
                    s_out_d = q_q[0];
                    if (!bus.rot && shifts_q != FULL)
                        shifts_d = shifts_q + ONE;
                end
                2'b11: begin
                    q_d        = bus.d;
                    shifts_d   = '0;
                    load_ack_d = 1'b1;
                end
            endcase
        end
    end

    // State registers; a cleared register counts as fully shifted out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q        <= '0;
            s_out_q    <= 1'b0;
            shifts_q   <= FULL;
            load_ack_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            s_out_q    <= s_out_d;
            shifts_q   <= shifts_d;
            load_ack_q <= load_ack_d;
        end
    end

    // Outputs straight from state; empty flag decoded from the tracker.
    always_comb begin
        bus.q        = q_q;
        bus.s_out    = s_out_q;
        bus.shifts   = shifts_q;
        bus.vacio    = (shifts_q == FULL);
        bus.load_ack = load_ack_q;
    end
endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed bench for shift_reg_universal with a queue-based scoreboard.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_shift_reg_universal;
    logic clk;
    logic reset;
    logic probe;

    shift_reg_universal_if #(.WIDTH(4), .CNT_W(3)) bus ();

    shift_reg_universal #(.WIDTH(4), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] q;
        logic       s;
        logic [2:0] sh;
        logic       v;
        logic       ack;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: compare one expectation per clock edge or reset probe.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge probe);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.q !== e.q || bus.s_out !== e.s ||
                    bus.shifts !== e.sh || bus.vacio !== e.v ||
                    bus.load_ack !== e.ack) begin
                    errors++;
                    $display("FAIL %s: got q=%b s=%b sh=%0d v=%b ack=%b want q=%b s=%b sh=%0d v=%b ack=%b",
                             e.name, bus.q, bus.s_out, bus.shifts, bus.vacio,
                             bus.load_ack, e.q, e.s, e.sh, e.v, e.ack);
                end
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] q, input logic s,
                                input logic [2:0] sh, input logic ack,
                                input string name);
        exp_t e;
        e.q    = q;
        e.s    = s;
        e.sh   = sh;
        e.v    = (sh == 3'd4);
        e.ack  = ack;
        e.name = name;
        return e;
    endfunction

    task automatic step(input logic en, input logic [1:0] md,
                        input logic rt, input logic sl, input logic sr,
                        input logic [3:0] dd, input logic [3:0] eq,
                        input logic es, input logic [2:0] esh,
                        input logic eack, input string name);
        @(negedge clk);
        bus.enable = en;
        bus.mode   = md;
        bus.rot    = rt;
        bus.s_in_l = sl;
        bus.s_in_r = sr;
        bus.d      = dd;
        sb.push_back(mk(eq, es, esh, eack, name));
    endtask

    task automatic rst_probe(input string name);
        @(negedge clk);
        reset = 1'b0;
        #2;
        sb.push_back(mk(4'b0000, 1'b0, 3'd4, 1'b0, name));
        probe = 1'b1;
        #1;
        probe = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [3:0] cq [5];
    logic       cs [5];
    logic [2:0] csh[5];
    logic       cak[5];

    initial begin
        checks     = 0;
        errors     = 0;
        probe      = 1'b0;
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.mode   = 2'b00;
        bus.rot    = 1'b0;
        bus.s_in_l = 1'b0;
        bus.s_in_r = 1'b0;
        bus.d      = 4'b0000;

        rst_probe("por");
        release_rst();

        // load then four plain left shifts
        step(1, 2'b11, 0, 0, 0, 4'b1011, 4'b1011, 0, 3'd0, 1, "ld1011");
        step(1, 2'b01, 0, 0, 0, 4'b0000, 4'b0110, 1, 3'd1, 0, "sl1");
        step(1, 2'b01, 0, 0, 0, 4'b0000, 4'b1100, 0, 3'd2, 0, "sl2");
        step(1, 2'b01, 0, 0, 0, 4'b0000, 4'b1000, 1, 3'd3, 0, "sl3");
        step(1, 2'b01, 0, 0, 0, 4'b0000, 4'b0000, 1, 3'd4, 0, "sl4");

        // reset mid-run, including while a load is presented
        step(1, 2'b11, 0, 0, 0, 4'b1011, 4'b1011, 1, 3'd0, 1, "ld_pre_rst");
        rst_probe("rst_async");
        step(1, 2'b11, 0, 0, 0, 4'b1111, 4'b0000, 0, 3'd4, 0, "rst_hold");
        release_rst();

        // right rotate keeps tracker at zero
        step(1, 2'b11, 1, 0, 0, 4'b0001, 4'b0001, 0, 3'd0, 1, "ld0001");
        step(1, 2'b10, 1, 0, 0, 4'b0000, 4'b1000, 1, 3'd0, 0, "rr1");
        step(1, 2'b10, 1, 0, 0, 4'b0000, 4'b0100, 0, 3'd0, 0, "rr2");
        step(1, 2'b10, 1, 0, 0, 4'b0000, 4'b0010, 0, 3'd0, 0, "rr3");
        step(1, 2'b10, 1, 0, 0, 4'b0000, 4'b0001, 0, 3'd0, 0, "rr4");
        step(1, 2'b10, 1, 0, 0, 4'b0000, 4'b1000, 1, 3'd0, 0, "rr5");

        // saturation with ones shifted in
        step(1, 2'b11, 0, 0, 1, 4'b0101, 4'b0101, 1, 3'd0, 1, "ld0101");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b1011, 0, 3'd1, 0, "sat1");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b0111, 1, 3'd2, 0, "sat2");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b1111, 0, 3'd3, 0, "sat3");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b1111, 1, 3'd4, 0, "sat4");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b1111, 1, 3'd4, 0, "sat5");
        step(1, 2'b01, 0, 0, 1, 4'b0000, 4'b1111, 1, 3'd4, 0, "sat6");

        // back-to-back loads, then gated left shifts
        step(1, 2'b11, 0, 0, 0, 4'b1001, 4'b1001, 1, 3'd0, 1, "ld_b2b1");
        step(1, 2'b11, 0, 0, 0, 4'b0110, 4'b0110, 1, 3'd0, 1, "ld_b2b2");
        step(0, 2'b01, 0, 0, 1, 4'b0000, 4'b0110, 1, 3'd0, 0, "gate1");
        step(0, 2'b01, 0, 0, 1, 4'b0000, 4'b0110, 1, 3'd0, 0, "gate2");
        step(0, 2'b01, 0, 0, 1, 4'b0000, 4'b0110, 1, 3'd0, 0, "gate3");

        // counter-driven modes: hold, left, right, load, hold
        cq  = '{4'b0110, 4'b1101, 4'b0110, 4'b1010, 4'b1010};
        cs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        csh = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0};
        cak = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            logic [1:0] cnt;
            cnt = 2'(i % 4);
            step(1, cnt, 0, 0, 1, 4'b1010, cq[i], cs[i], csh[i], cak[i],
                 $sformatf("cnt%0d", i));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
